// File: rtl/ahblite_master_arb2_if.sv
// One AHB-lite link: the master modport drives the address/control and write
// data, while the slave modport returns ready and read data.
interface ahblite_master_arb2_if #(
   parameter int AW = 32,
   parameter int DW = 64
);
   logic [AW-1:0] HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [DW-1:0] HWDATA;
   logic          HREADY;
   logic [DW-1:0] HRDATA;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      input  HREADY, HRDATA
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      output HREADY, HRDATA
   );
endinterface

// File: rtl/ahblite_master_arb2.sv
// Two-master AHB-lite arbiter. It merges M0 (instruction fetch) and M1
// (load/store) onto one downstream AHB-lite port. Arbitration is round-robin.
// If a master loses, or the bus is stalled, its address phase is captured in
// a hold register and issued later, and the master is stalled until then.
module ahblite_master_arb2 #(
   parameter int AW = 32,
   parameter int DW = 64
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   ahblite_master_arb2_if.slave  m0,
   ahblite_master_arb2_if.slave  m1,
   ahblite_master_arb2_if.master sys,
   output logic                  HMASTER
);

   logic [1:0]         in_req;
   logic [1:0][AW-1:0] in_addr;
   logic [1:0]         in_write;
   logic [1:0][2:0]    in_size;

   logic [1:0]         hready_m;
   logic [1:0]         live;
   logic [1:0]         req;
   logic [1:0][AW-1:0] sel_addr;
   logic [1:0]         sel_write;
   logic [1:0][2:0]    sel_size;

   logic [1:0]         pend_q, pend_d;
   logic [1:0][AW-1:0] hold_addr_q, hold_addr_d;
   logic [1:0]         hold_write_q, hold_write_d;
   logic [1:0][2:0]    hold_size_q, hold_size_d;
   logic               dph_v_q, dph_v_d;
   logic               dph_own_q, dph_own_d;
   logic               last_q, last_d;

   logic               gnt_v;
   logic               gnt;
   logic               accept;

   // HTRANS[0] separates NONSEQ from SEQ. Every issued transfer goes out as
   // NONSEQ, so that bit is not needed.
   logic               unused_seq;
   assign unused_seq = m0.HTRANS[0] ^ m1.HTRANS[0];

   assign in_req[0]   = m0.HTRANS[1];
   assign in_req[1]   = m1.HTRANS[1];
   assign in_addr[0]  = m0.HADDR;
   assign in_addr[1]  = m1.HADDR;
   assign in_write[0] = m0.HWRITE;
   assign in_write[1] = m1.HWRITE;
   assign in_size[0]  = m0.HSIZE;
   assign in_size[1]  = m1.HSIZE;

   // Per-master ready, live request detection and attribute source selection.
   // Reset gates the live term so that the bus goes idle while reset is held.
   always_comb begin
      for (int x = 0; x < 2; x++) begin
         hready_m[x] = 1'b1;
         if (pend_q[x])
            hready_m[x] = 1'b0;
         else if (dph_v_q && (dph_own_q == x[0]))
            hready_m[x] = sys.HREADY;
         live[x]      = in_req[x] & hready_m[x] & ~HRESET;
         sel_addr[x]  = pend_q[x] ? hold_addr_q[x]  : in_addr[x];
         sel_write[x] = pend_q[x] ? hold_write_q[x] : in_write[x];
         sel_size[x]  = pend_q[x] ? hold_size_q[x]  : in_size[x];
      end
   end

   assign req    = pend_q | live;
   assign gnt_v  = |req;
   assign gnt    = (req == 2'b11) ? ~last_q : req[1];
   assign accept = gnt_v & sys.HREADY;

   assign sys.HTRANS = gnt_v ? 2'b10 : 2'b00;
   assign sys.HADDR  = gnt_v ? sel_addr[gnt]  : '0;
   assign sys.HWRITE = gnt_v ? sel_write[gnt] : 1'b0;
   assign sys.HSIZE  = gnt_v ? sel_size[gnt]  : 3'd0;
   assign sys.HWDATA = dph_own_q ? m1.HWDATA : m0.HWDATA;
   assign HMASTER    = gnt_v & gnt;

   assign m0.HREADY = hready_m[0];
   assign m1.HREADY = hready_m[1];
   assign m0.HRDATA = sys.HRDATA;
   assign m1.HRDATA = sys.HRDATA;

   // Next state: grant bookkeeping on accept, and capture of live requests
   // that were not accepted.
   always_comb begin
      pend_d       = pend_q;
      hold_addr_d  = hold_addr_q;
      hold_write_d = hold_write_q;
      hold_size_d  = hold_size_q;
      dph_v_d      = dph_v_q;
      dph_own_d    = dph_own_q;
      last_d       = last_q;
      if (accept) begin
         pend_d[gnt] = 1'b0;
         dph_v_d     = 1'b1;
         dph_own_d   = gnt;
         last_d      = gnt;
      end else if (sys.HREADY) begin
         dph_v_d = 1'b0;
      end
      for (int x = 0; x < 2; x++) begin
         if (live[x] && !(accept && (gnt == x[0]))) begin
            pend_d[x]       = 1'b1;
            hold_addr_d[x]  = in_addr[x];
            hold_write_d[x] = in_write[x];
            hold_size_d[x]  = in_size[x];
         end
      end
   end

   // State registers. last resets to 1 so that M0 wins the first tie.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         pend_q       <= 2'b00;
         hold_addr_q  <= '0;
         hold_write_q <= 2'b00;
         hold_size_q  <= '0;
         dph_v_q      <= 1'b0;
         dph_own_q    <= 1'b0;
         last_q       <= 1'b1;
      end else begin
         pend_q       <= pend_d;
         hold_addr_q  <= hold_addr_d;
         hold_write_q <= hold_write_d;
         hold_size_q  <= hold_size_d;
         dph_v_q      <= dph_v_d;
         dph_own_q    <= dph_own_d;
         last_q       <= last_d;
      end
   end

endmodule

// File: tb/tb_ahblite_master_arb2.sv
// Bench for ahblite_master_arb2: directed scenarios, then random traffic
// checked against transaction-level per-master order queues.
module tb_ahblite_master_arb2;
   localparam int AW = 32;
   localparam int DW = 64;

   typedef struct packed {
      logic [31:0] addr;
      logic        w;
      logic [2:0]  sz;
      logic [63:0] wd;
   } xfer_t;

   logic HCLK = 1'b0;
   logic HRESET = 1'b1;
   logic HMASTER;

   ahblite_master_arb2_if #(.AW(AW), .DW(DW)) m0_if ();
   ahblite_master_arb2_if #(.AW(AW), .DW(DW)) m1_if ();
   ahblite_master_arb2_if #(.AW(AW), .DW(DW)) sys_if ();

   ahblite_master_arb2 #(.AW(AW), .DW(DW)) dut (
      .HCLK    (HCLK),
      .HRESET  (HRESET),
      .m0      (m0_if),
      .m1      (m1_if),
      .sys     (sys_if),
      .HMASTER (HMASTER)
   );

   always #5 HCLK = ~HCLK;

   int n_chk = 0;
   int n_err = 0;

   xfer_t xq0[$];
   xfer_t xq1[$];
   xfer_t m_cur[2];
   xfer_t m_dx[2];
   xfer_t s_dx;
   bit    m_req[2];
   bit    m_dv[2];
   bit    s_dv;
   logic [1:0] m_tr[2];
   int    m_wait[2];
   int    ws_cnt = 0;
   int    n_issued = 0;
   int    n_done = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] rd_pat(input logic [31:0] a);
      return {a ^ 32'hA5A5_5A5A, ~a};
   endfunction

   task automatic drv_m(input int x, input logic [1:0] tr, input logic [31:0] a,
                        input logic w, input logic [2:0] sz, input logic [63:0] wd);
      if (x == 0) begin
         m0_if.HTRANS = tr; m0_if.HADDR = a; m0_if.HWRITE = w;
         m0_if.HSIZE = sz; m0_if.HWDATA = wd;
      end else begin
         m1_if.HTRANS = tr; m1_if.HADDR = a; m1_if.HWRITE = w;
         m1_if.HSIZE = sz; m1_if.HWDATA = wd;
      end
   endtask

   task automatic idle_all();
      drv_m(0, 2'b00, 32'h0, 1'b0, 3'd0, 64'h0);
      drv_m(1, 2'b00, 32'h0, 1'b0, 3'd0, 64'h0);
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      idle_all();
      sys_if.HREADY = 1'b1;
      sys_if.HRDATA = 64'h0;
      repeat (2) @(negedge HCLK);
      HRESET = 1'b0;
   endtask

   function automatic bit busy_f();
      return m_req[0] | m_req[1] | m_dv[0] | m_dv[1] | s_dv |
             (xq0.size() != 0) | (xq1.size() != 0);
   endfunction

   // One random bus cycle: drive masters and slave, then update the
   // transaction model with what the coming edge will commit.
   task automatic run_cycle(input bit drain);
      xfer_t       t;
      logic        hr;
      logic [63:0] rd;
      @(negedge HCLK);
      if (ws_cnt < 3 && $urandom_range(0, 3) == 0) begin
         sys_if.HREADY = 1'b0;
         ws_cnt++;
      end else begin
         sys_if.HREADY = 1'b1;
         ws_cnt = 0;
      end
      sys_if.HRDATA = s_dv ? rd_pat(s_dx.addr) : {$urandom, $urandom};
      for (int x = 0; x < 2; x++) begin
         if (!m_req[x] && !drain && $urandom_range(0, 2) != 0) begin
            m_cur[x].addr = $urandom & 32'hFFFF_FFF8;
            m_cur[x].w    = 1'($urandom_range(0, 1));
            m_cur[x].sz   = 3'($urandom_range(0, 3));
            m_cur[x].wd   = {$urandom, $urandom};
            m_tr[x]       = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
            m_req[x]      = 1'b1;
            m_wait[x]     = 0;
         end
         if (m_req[x])
            drv_m(x, m_tr[x], m_cur[x].addr, m_cur[x].w, m_cur[x].sz,
                  m_dv[x] ? m_dx[x].wd : {$urandom, $urandom});
         else
            drv_m(x, {1'b0, 1'($urandom_range(0, 1))}, $urandom, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), m_dv[x] ? m_dx[x].wd : {$urandom, $urandom});
      end
      #1;
      if (sys_if.HTRANS != 2'b10) begin
         chk("idle_htrans", 64'(sys_if.HTRANS), 64'h0);
         chk("idle_haddr", 64'(sys_if.HADDR), 64'h0);
         chk("idle_hmaster", 64'(HMASTER), 64'h0);
      end
      for (int x = 0; x < 2; x++) begin
         hr = (x == 0) ? m0_if.HREADY : m1_if.HREADY;
         rd = (x == 0) ? m0_if.HRDATA : m1_if.HRDATA;
         if (hr) begin
            if (m_dv[x]) begin
               if (!m_dx[x].w) chk("rd_data", rd, rd_pat(m_dx[x].addr));
               m_dv[x] = 1'b0;
               n_done++;
            end
            if (m_req[x]) begin
               t = m_cur[x];
               if (x == 0) xq0.push_back(t);
               else        xq1.push_back(t);
               m_dx[x]  = t;
               m_dv[x]  = 1'b1;
               m_req[x] = 1'b0;
               n_issued++;
            end
         end else if (m_req[x]) begin
            m_wait[x]++;
            chk("stall_bound", 64'(m_wait[x] > 40), 64'h0);
         end
      end
      if (sys_if.HREADY) begin
         if (s_dv) begin
            if (s_dx.w) chk("wr_data", sys_if.HWDATA, s_dx.wd);
            s_dv = 1'b0;
         end
         if (sys_if.HTRANS == 2'b10) begin
            if ((HMASTER && xq1.size() == 0) || (!HMASTER && xq0.size() == 0)) begin
               chk("unexpected_xfer", 64'h1, 64'h0);
            end else begin
               if (HMASTER) t = xq1.pop_front();
               else         t = xq0.pop_front();
               chk("xfer_addr", 64'(sys_if.HADDR), 64'(t.addr));
               chk("xfer_write", 64'(sys_if.HWRITE), 64'(t.w));
               chk("xfer_size", 64'(sys_if.HSIZE), 64'(t.sz));
               s_dx = t;
               s_dv = 1'b1;
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Idle after reset
      do_reset();
      @(negedge HCLK); #1;
      chk("rst_htrans", 64'(sys_if.HTRANS), 64'h0);
      chk("rst_haddr", 64'(sys_if.HADDR), 64'h0);
      chk("rst_hmaster", 64'(HMASTER), 64'h0);
      chk("rst_hready_m0", 64'(m0_if.HREADY), 64'h1);
      chk("rst_hready_m1", 64'(m1_if.HREADY), 64'h1);

      // Single uncontested M0 read
      @(negedge HCLK);
      drv_m(0, 2'b10, 32'h0000_1000, 1'b0, 3'd3, 64'h0);
      #1;
      chk("single_htrans", 64'(sys_if.HTRANS), 64'h2);
      chk("single_haddr", 64'(sys_if.HADDR), 64'h1000);
      @(negedge HCLK);
      idle_all();
      sys_if.HRDATA = 64'h1122_3344_5566_7788;
      #1;
      chk("single_rdata", m0_if.HRDATA, 64'h1122_3344_5566_7788);
      chk("single_hready_m0", 64'(m0_if.HREADY), 64'h1);

      // Simultaneous requests after reset: M0 first, then pended M1
      do_reset();
      @(negedge HCLK);
      drv_m(0, 2'b10, 32'h100, 1'b0, 3'd3, 64'h0);
      drv_m(1, 2'b10, 32'h200, 1'b0, 3'd3, 64'h0);
      #1;
      chk("tie_c0_hmaster", 64'(HMASTER), 64'h0);
      chk("tie_c0_haddr", 64'(sys_if.HADDR), 64'h100);
      @(negedge HCLK);
      idle_all();
      #1;
      chk("tie_c1_hmaster", 64'(HMASTER), 64'h1);
      chk("tie_c1_haddr", 64'(sys_if.HADDR), 64'h200);
      chk("tie_c1_htrans", 64'(sys_if.HTRANS), 64'h2);
      chk("tie_c1_hready_m1", 64'(m1_if.HREADY), 64'h0);
      @(negedge HCLK);
      sys_if.HREADY = 1'b0;
      #1;
      chk("tie_c2_hready_m1_lo", 64'(m1_if.HREADY), 64'h0);
      chk("tie_c2_htrans", 64'(sys_if.HTRANS), 64'h0);
      sys_if.HREADY = 1'b1;
      #1;
      chk("tie_c2_hready_m1_hi", 64'(m1_if.HREADY), 64'h1);

      // Continuous requests from both: strict alternation
      do_reset();
      @(negedge HCLK);
      drv_m(0, 2'b10, 32'h1000, 1'b0, 3'd3, 64'h0);
      drv_m(1, 2'b10, 32'h2000, 1'b0, 3'd3, 64'h0);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge HCLK);
         #1;
         chk($sformatf("rr_hmaster_%0d", i), 64'(HMASTER), 64'(i % 2));
         chk($sformatf("rr_htrans_%0d", i), 64'(sys_if.HTRANS), 64'h2);
      end

      // Pended M1 write with two downstream wait states
      do_reset();
      @(negedge HCLK);
      drv_m(0, 2'b10, 32'h300, 1'b0, 3'd3, 64'h0BAD_0BAD_0BAD_0BAD);
      drv_m(1, 2'b10, 32'h400, 1'b1, 3'd3, 64'h0);
      #1;
      chk("wr_c0_hmaster", 64'(HMASTER), 64'h0);
      @(negedge HCLK);
      drv_m(0, 2'b00, 32'h0, 1'b0, 3'd0, 64'h0BAD_0BAD_0BAD_0BAD);
      drv_m(1, 2'b00, 32'h0, 1'b0, 3'd0, 64'hDEAD_BEEF_CAFE_F00D);
      #1;
      chk("wr_c1_hmaster", 64'(HMASTER), 64'h1);
      chk("wr_c1_hwrite", 64'(sys_if.HWRITE), 64'h1);
      chk("wr_c1_hready_m1", 64'(m1_if.HREADY), 64'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge HCLK);
         sys_if.HREADY = 1'b0;
         #1;
         chk($sformatf("wr_ws%0d_hwdata", i), sys_if.HWDATA, 64'hDEAD_BEEF_CAFE_F00D);
         chk($sformatf("wr_ws%0d_hready_m1", i), 64'(m1_if.HREADY), 64'h0);
      end
      @(negedge HCLK);
      sys_if.HREADY = 1'b1;
      #1;
      chk("wr_done_hwdata", sys_if.HWDATA, 64'hDEAD_BEEF_CAFE_F00D);
      chk("wr_done_hready_m1", 64'(m1_if.HREADY), 64'h1);

      // Reset in the middle of a cycle with M1 pended and a data phase open
      do_reset();
      @(negedge HCLK);
      drv_m(0, 2'b10, 32'h100, 1'b0, 3'd3, 64'h0);
      drv_m(1, 2'b10, 32'h200, 1'b0, 3'd3, 64'h0);
      @(negedge HCLK);
      drv_m(0, 2'b10, 32'h500, 1'b0, 3'd3, 64'h0);
      drv_m(1, 2'b00, 32'h0, 1'b0, 3'd0, 64'h0);
      sys_if.HREADY = 1'b0;
      #3;
      HRESET = 1'b1;
      #1;
      chk("mrst_htrans", 64'(sys_if.HTRANS), 64'h0);
      chk("mrst_hready_m0", 64'(m0_if.HREADY), 64'h1);
      chk("mrst_hready_m1", 64'(m1_if.HREADY), 64'h1);
      @(negedge HCLK);
      HRESET = 1'b0;
      sys_if.HREADY = 1'b1;
      drv_m(0, 2'b10, 32'h100, 1'b0, 3'd3, 64'h0);
      drv_m(1, 2'b10, 32'h200, 1'b0, 3'd3, 64'h0);
      #1;
      chk("mrst_tie_hmaster", 64'(HMASTER), 64'h0);
      chk("mrst_tie_haddr", 64'(sys_if.HADDR), 64'h100);

      // Random traffic against the transaction model
      do_reset();
      for (int i = 0; i < 3000; i++) run_cycle(1'b0);
      for (int i = 0; i < 300 && busy_f(); i++) run_cycle(1'b1);
      chk("drain_idle", 64'(busy_f()), 64'h0);
      chk("issued_vs_done", 64'(n_done), 64'(n_issued));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
